// File: rtl/expansion_pkg.sv
// Shared types and helpers for the expansion shift-register port controller.
package expansion_pkg;

  // Frame sequencer states, in the order a frame visits them.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT    = 3'd1,
    ST_LATCH_LO = 3'd2,
    ST_LATCH_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Busy cycles of one complete frame: shift bits, latch low/high, done.
  function automatic int unsigned frame_cycles(input int unsigned width,
                                               input int unsigned divider);
    return width * 32'd2 * divider + 32'd2 * divider + 32'd1;
  endfunction

endpackage

// File: rtl/shiftreg_phase_timer.sv
// Phase timer: raises tick_o on the last cycle of every DIVIDER-cycle phase
// while run_i is high; idles at zero so each frame starts on a phase boundary.
module shiftreg_phase_timer #(
  parameter int unsigned DIVIDER = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(DIVIDER - 1) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = run_i && (cnt_q == LAST);

  // Next count: wrap at the end of each phase, park at zero when not running.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Phase counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/expansion_shiftreg_ctrl.sv
// Frame scheduler for a 595 output chain and 165 input chain sharing CLOCK
// and LOAD. Frames start on host writes or the refresh timer; all pin
// outputs are registered from next-state values so they align with state.
// WIDTH must be at least 2.
module expansion_shiftreg_ctrl
  import expansion_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIVIDER = 2,
  parameter int unsigned REFRESH = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] out_data,
  input  logic             out_wr,
  output logic [WIDTH-1:0] in_data,
  output logic             in_valid,
  output logic             busy,
  output logic             SHIFT_OUT,
  input  logic             SHIFT_IN,
  output logic             SHIFT_CLK,
  output logic             SHIFT_LOAD
);

  localparam int unsigned REF_MAX_I = (REFRESH == 32'd0) ? 32'd0 : REFRESH - 32'd1;
  localparam int unsigned RW = $clog2(REF_MAX_I) + 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REF_MAX_I);
  localparam int unsigned BW = $clog2(WIDTH - 1) + 1;
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             phase_hi_q, phase_hi_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_out_q, sr_out_d;
  logic [WIDTH-1:0] sr_in_q, sr_in_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] in_data_q, in_data_d;
  logic             in_valid_q, in_valid_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             tick_s;
  logic             run_s;
  logic             start_s;

  assign run_s   = (state_q == ST_SHIFT) || (state_q == ST_LATCH_LO) ||
                   (state_q == ST_LATCH_HI);
  assign start_s = (state_q == ST_IDLE) && enable &&
                   (pending_q || ((REFRESH != 32'd0) && (ref_q == REF_MAX)));

  shiftreg_phase_timer #(.DIVIDER(DIVIDER)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (run_s),
    .tick_o (tick_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a frame walks SHIFT, LATCH_LO, LATCH_HI, DONE back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = start_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:    state_d = (tick_s && phase_hi_q && (bit_q == BW'(0))) ? ST_LATCH_LO : ST_SHIFT;
      ST_LATCH_LO: state_d = tick_s ? ST_LATCH_HI : ST_LATCH_LO;
      ST_LATCH_HI: state_d = tick_s ? ST_DONE : ST_LATCH_HI;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: shift registers, host buffer, refresh and capture.
  always_comb begin
    phase_hi_d = 1'b0;
    bit_d      = bit_q;
    sr_out_d   = sr_out_q;
    sr_in_d    = sr_in_q;
    in_data_d  = in_data_q;
    in_valid_d = 1'b0;
    primed_d   = primed_q;
    shadow_d   = out_wr ? out_data : shadow_q;
    if (out_wr) begin
      pending_d = 1'b1;
    end else if (start_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (start_s) begin
      ref_d = '0;
    end else if (ref_q == REF_MAX) begin
      ref_d = ref_q;
    end else begin
      ref_d = ref_q + RW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          bit_d    = BIT_TOP;
          sr_out_d = shadow_q;
        end else begin
          bit_d    = bit_q;
        end
      end
      ST_SHIFT: begin
        phase_hi_d = tick_s ? ~phase_hi_q : phase_hi_q;
        if (tick_s && !phase_hi_q) begin
          // End of low phase: the 165 output is settled, take it MSB first.
          sr_in_d = {sr_in_q[WIDTH-2:0], SHIFT_IN};
        end else if (tick_s && phase_hi_q) begin
          // End of high phase: present the next output bit.
          sr_out_d = {sr_out_q[WIDTH-2:0], 1'b0};
          bit_d    = (bit_q == BW'(0)) ? bit_q : bit_q - BW'(1);
        end else begin
          sr_in_d  = sr_in_q;
        end
      end
      ST_LATCH_HI: begin
        if (tick_s) begin
          // Entering DONE: the first frame only primes the 165 pipeline.
          in_data_d  = primed_q ? sr_in_q : in_data_q;
          in_valid_d = primed_q;
          primed_d   = 1'b1;
        end else begin
          in_valid_d = 1'b0;
        end
      end
      default: begin
        phase_hi_d = 1'b0;
      end
    endcase
  end

  // Pin outputs derived from next-state values so they register in step.
  always_comb begin
    sclk_d = (state_d == ST_SHIFT) && phase_hi_d;
    load_d = (state_d != ST_LATCH_LO);
    sout_d = (state_d == ST_SHIFT) ? sr_out_d[WIDTH-1] : 1'b0;
    busy_d = (state_d != ST_IDLE);
  end

  // Datapath and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_hi_q <= 1'b0;
      bit_q      <= '0;
      sr_out_q   <= '0;
      sr_in_q    <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b1;
      ref_q      <= '0;
      primed_q   <= 1'b0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      load_q     <= 1'b1;
      sout_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      phase_hi_q <= phase_hi_d;
      bit_q      <= bit_d;
      sr_out_q   <= sr_out_d;
      sr_in_q    <= sr_in_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      ref_q      <= ref_d;
      primed_q   <= primed_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      sclk_q     <= sclk_d;
      load_q     <= load_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
    end
  end

  assign in_data    = in_data_q;
  assign in_valid   = in_valid_q;
  assign busy       = busy_q;
  assign SHIFT_OUT  = sout_q;
  assign SHIFT_CLK  = sclk_q;
  assign SHIFT_LOAD = load_q;

endmodule

// File: tb/tb_expansion_shiftreg_ctrl.sv
// Directed bench: 595/165 chain models, a vector table and corner sequences.
module tb_expansion_shiftreg_ctrl;
  import expansion_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, rst_aux_n = 1'b0, enable = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       out_wr = 1'b0;
  logic [7:0] in_data;
  logic       in_valid, busy, shift_out, shift_in, shift_clk, shift_load;

  // Auxiliary instances for refresh behaviour.
  logic [7:0] r_in_data, z_in_data;
  logic       r_in_valid, r_busy, r_sout, r_sclk, r_load;
  logic       z_in_valid, z_busy, z_sout, z_sclk, z_load;

  int checks = 0, failures = 0;
  int cyc = 0;

  // External chain models.
  logic [7:0] par165 = 8'h00, r165 = 8'h00, r595 = 8'h00, latch595 = 8'h00;
  logic       sclk_prev = 1'b0, load_prev = 1'b1;
  assign shift_in = r165[7];

  expansion_shiftreg_ctrl #(.WIDTH(8), .DIVIDER(2), .REFRESH(50000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .out_data(out_data), .out_wr(out_wr),
    .in_data(in_data), .in_valid(in_valid), .busy(busy), .SHIFT_OUT(shift_out),
    .SHIFT_IN(shift_in), .SHIFT_CLK(shift_clk), .SHIFT_LOAD(shift_load));

  expansion_shiftreg_ctrl #(.WIDTH(8), .DIVIDER(2), .REFRESH(100)) dut_r (
    .clk(clk), .rst_n(rst_aux_n), .enable(1'b1), .out_data(8'h00), .out_wr(1'b0),
    .in_data(r_in_data), .in_valid(r_in_valid), .busy(r_busy), .SHIFT_OUT(r_sout),
    .SHIFT_IN(1'b0), .SHIFT_CLK(r_sclk), .SHIFT_LOAD(r_load));

  expansion_shiftreg_ctrl #(.WIDTH(8), .DIVIDER(1), .REFRESH(0)) dut_z (
    .clk(clk), .rst_n(rst_aux_n), .enable(1'b1), .out_data(8'h00), .out_wr(1'b0),
    .in_data(z_in_data), .in_valid(z_in_valid), .busy(z_busy), .SHIFT_OUT(z_sout),
    .SHIFT_IN(1'b0), .SHIFT_CLK(z_sclk), .SHIFT_LOAD(z_load));

  always @(posedge clk) cyc <= cyc + 1;

  // 595 shifts on CLOCK rise and latches on LOAD rise; 165 loads while LOAD low.
  always @(posedge clk) begin
    sclk_prev <= shift_clk;
    load_prev <= shift_load;
    if (!shift_load) r165 <= par165;
    else if (shift_clk && !sclk_prev) r165 <= {r165[6:0], 1'b0};
    if (shift_clk && !sclk_prev) r595 <= {r595[6:0], shift_out};
    if (shift_load && !load_prev) latch595 <= r595;
  end

  // Frame-start monitors for the auxiliary instances.
  int r_start[4];
  int r_n = 0, z_n = 0, z_busy_total = 0;
  logic r_busy_prev = 1'b0, z_busy_prev = 1'b0;
  always @(negedge clk) begin
    r_busy_prev <= r_busy;
    z_busy_prev <= z_busy;
    if (r_busy && !r_busy_prev) begin
      if (r_n < 4) r_start[r_n] <= cyc;
      r_n <= r_n + 1;
    end
    if (z_busy && !z_busy_prev) z_n <= z_n + 1;
    if (z_busy) z_busy_total <= z_busy_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] v);
    @(negedge clk);
    out_data = v;
    out_wr   = 1'b1;
    @(negedge clk);
    out_wr   = 1'b0;
  endtask

  task automatic wait_busy();
    int guard;
    guard = 0;
    while (!busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("busy_seen", busy, 1);
  endtask

  // Waits for a frame (bounded) and measures it until busy falls.
  task automatic run_frame(output int busy_cyc, output int rises, output int load_lo,
                           output int valids, output logic [7:0] bits);
    int guard;
    logic prev;
    busy_cyc = 0; rises = 0; load_lo = 0; valids = 0; bits = 8'h00; prev = 1'b0;
    wait_busy();
    guard = 0;
    while (busy && guard < 500) begin
      busy_cyc++;
      if (shift_clk && !prev) begin
        rises++;
        bits = {bits[6:0], shift_out};
      end
      prev = shift_clk;
      if (!shift_load) load_lo++;
      if (in_valid) valids++;
      @(negedge clk);
      guard++;
    end
    check("busy_end_seen", busy, 0);
  endtask

  typedef struct {
    logic [7:0] wr;
    logic [7:0] par;
    logic [7:0] exp_latch;
    int         exp_valid;
    logic [7:0] exp_in;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bc, rs, ll, vc, idle_busy;
    logic [7:0] bits;
    // in_data of each frame is the parallel word captured one frame earlier.
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 1, 8'h5A};
    vecs[1] = '{8'h0F, 8'hC3, 8'h0F, 1, 8'h3C};
    vecs[2] = '{8'h80, 8'hFF, 8'h80, 1, 8'hC3};
    vecs[3] = '{8'h01, 8'h00, 8'h01, 1, 8'hFF};
    vecs[4] = '{8'hFF, 8'h81, 8'hFF, 1, 8'h00};

    // Reset state and first (priming) frame.
    enable = 1'b1;
    par165 = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_sclk", shift_clk, 0);
    check("rst_load", shift_load, 1);
    check("rst_sout", shift_out, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", in_valid, 0);
    check("rst_in_data", in_data, 0);
    rst_n = 1'b1;
    rst_aux_n = 1'b1;
    @(negedge clk);
    check("start_cycle1", busy, 1);
    run_frame(bc, rs, ll, vc, bits);
    check("prime_busy_len", bc, frame_cycles(8, 2));
    check("prime_rises", rs, 8);
    check("prime_load_lo", ll, 2);
    check("prime_no_valid", vc, 0);
    check("prime_bits", bits, 8'h00);

    // Table of write/parallel-input frames.
    for (int i = 0; i < 5; i++) begin
      par165 = vecs[i].par;
      write_word(vecs[i].wr);
      run_frame(bc, rs, ll, vc, bits);
      check($sformatf("vec%0d_bits", i), bits, vecs[i].exp_latch);
      check($sformatf("vec%0d_latch", i), latch595, vecs[i].exp_latch);
      check($sformatf("vec%0d_valid", i), vc, vecs[i].exp_valid);
      check($sformatf("vec%0d_in_data", i), in_data, vecs[i].exp_in);
      check($sformatf("vec%0d_busy_len", i), bc, 37);
    end

    // Two writes during a busy frame: one follow-up frame with the latest.
    write_word(8'h44);
    wait_busy();
    repeat (3) @(negedge clk);
    write_word(8'h11);
    repeat (4) @(negedge clk);
    write_word(8'h22);
    run_frame(bc, rs, ll, vc, bits);
    check("wr44_latch", latch595, 8'h44);
    run_frame(bc, rs, ll, vc, bits);
    check("wr22_bits", bits, 8'h22);
    check("wr22_latch", latch595, 8'h22);
    idle_busy = 0;
    repeat (80) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    check("no_extra_frame", idle_busy, 0);

    // enable dropped mid-frame: frame completes, write held until enable returns.
    write_word(8'h5A);
    wait_busy();
    repeat (4) @(negedge clk);
    enable = 1'b0;
    write_word(8'h3C);
    run_frame(bc, rs, ll, vc, bits);
    check("en_off_latch", latch595, 8'h5A);
    idle_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    check("en_off_blocks", idle_busy, 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_on_start", busy, 1);
    run_frame(bc, rs, ll, vc, bits);
    check("en_on_latch", latch595, 8'h3C);
    check("en_on_in_data", in_data, 8'h81);

    // Reset at cycle 10 of a frame, then a priming frame without in_valid.
    write_word(8'h99);
    wait_busy();
    repeat (9) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_sclk", shift_clk, 0);
    check("mid_rst_load", shift_load, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_data", in_data, 0);
    rst_n = 1'b1;
    run_frame(bc, rs, ll, vc, bits);
    check("reprime_no_valid", vc, 0);
    check("reprime_busy_len", bc, 37);
    check("reprime_latch", latch595, 8'h00);

    // Refresh instances.
    repeat (150) @(negedge clk);
    check("ref_frames", (r_n >= 4) ? 1 : 0, 1);
    check("ref_period0", r_start[1] - r_start[0], 100);
    check("ref_period1", r_start[2] - r_start[1], 100);
    check("ref_period2", r_start[3] - r_start[2], 100);
    check("noref_frames", z_n, 1);
    check("noref_busy_len", z_busy_total, frame_cycles(8, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
